ball_renderer: RTL and testbench

BALL_RENDERER -- requirements
Module: ball_renderer

---
 rtl/ball_renderer.sv | 165 ++++++++++++++++
 tb/tb_ball_renderer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_renderer.sv
// Bouncing-ball sprite: once-per-frame physics FSM plus a two-stage pixel colour pipeline.
// Physics updates a private position; the renderer only ever reads the committed display copy.
module ball_renderer #(
  parameter int          H_ACTIVE  = 1600,
  parameter int          V_ACTIVE  = 1200,
  parameter int          BALL_SIZE = 16,
  parameter int          GRAVITY   = 1,
  parameter int          VMAX      = 24,
  parameter int          X0        = 100,
  parameter int          Y0        = 100,
  parameter int          VX0       = 3,
  parameter int          VY0       = 0,
  parameter logic [11:0] BALL_RGB  = 12'hF80,
  parameter logic [11:0] BG_RGB    = 12'h004
) (
  input  logic        clock_162,
  input  logic        rst,
  input  logic [10:0] px_col,
  input  logic [10:0] px_row,
  input  logic        px_valid,
  input  logic        frame_start,
  output logic [3:0]  RED,
  output logic [3:0]  GREEN,
  output logic [3:0]  BLUE,
  output logic        rgb_valid,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, GRAV, MOVE, BOUNCE, COMMIT} state_t;

  localparam logic signed [12:0] VMAX_S   = 13'(VMAX);
  localparam logic signed [12:0] VMIN_S   = 13'(-VMAX);
  localparam logic signed [12:0] X_LIM_S  = 13'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [12:0] Y_LIM_S  = 13'(V_ACTIVE - BALL_SIZE);
  localparam logic [12:0]        BALL_EXT = 13'(BALL_SIZE);

  state_t             state_reg;
  logic               busy_reg;
  logic [11:0]        px_reg, py_reg, dx_reg, dy_reg;
  logic signed [11:0] vx_reg, vy_reg;
  logic signed [12:0] nx_reg, ny_reg;

  logic signed [12:0] vy_grav;
  logic signed [11:0] vy_sat;
  logic signed [12:0] nx_next, ny_next;

  // Gravity is added in 13 bits so the saturation compare sees the true sum.
  assign vy_grav = {vy_reg[11], vy_reg} + 13'(GRAVITY);
  assign nx_next = {1'b0, px_reg} + {vx_reg[11], vx_reg};
  assign ny_next = {1'b0, py_reg} + {vy_reg[11], vy_reg};

  always_comb begin
    vy_sat = vy_grav[11:0];
    if (vy_grav > VMAX_S)
      vy_sat = VMAX_S[11:0];
    else if (vy_grav < VMIN_S)
      vy_sat = VMIN_S[11:0];
  end

  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      px_reg    <= 12'(X0);
      py_reg    <= 12'(Y0);
      dx_reg    <= 12'(X0);
      dy_reg    <= 12'(Y0);
      vx_reg    <= 12'(VX0);
      vy_reg    <= 12'(VY0);
      nx_reg    <= '0;
      ny_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (frame_start) begin
            state_reg <= GRAV;
            busy_reg  <= 1'b1;
          end
        end
        GRAV: begin
          vy_reg    <= vy_sat;
          state_reg <= MOVE;
        end
        MOVE: begin
          nx_reg    <= nx_next;
          ny_reg    <= ny_next;
          state_reg <= BOUNCE;
        end
        BOUNCE: begin
          if (ny_reg >= Y_LIM_S) begin
            py_reg <= Y_LIM_S[11:0];
            vy_reg <= -vy_reg;
          end else if (ny_reg[12]) begin
            py_reg <= '0;
            vy_reg <= -vy_reg;
          end else begin
            py_reg <= ny_reg[11:0];
          end
          if (nx_reg >= X_LIM_S) begin
            px_reg <= X_LIM_S[11:0];
            vx_reg <= -vx_reg;
          end else if (nx_reg[12]) begin
            px_reg <= '0;
            vx_reg <= -vx_reg;
          end else begin
            px_reg <= nx_reg[11:0];
          end
          state_reg <= COMMIT;
        end
        COMMIT: begin
          dx_reg    <= px_reg;
          dy_reg    <= py_reg;
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;

  logic [12:0] col_ext, row_ext, dx_ext, dy_ext;
  logic        hit_next;
  logic        hit_reg, valid_reg;
  logic [11:0] rgb_reg;
  logic        rgb_valid_reg;

  // Bounds are widened to 13 bits so dx+BALL_SIZE can never wrap.
  assign col_ext  = {2'b00, px_col};
  assign row_ext  = {2'b00, px_row};
  assign dx_ext   = {1'b0, dx_reg};
  assign dy_ext   = {1'b0, dy_reg};
  assign hit_next = px_valid
                  & (col_ext >= dx_ext) & (col_ext < dx_ext + BALL_EXT)
                  & (row_ext >= dy_ext) & (row_ext < dy_ext + BALL_EXT);

  always_ff @(posedge clock_162 or posedge rst) begin
    if (rst) begin
      hit_reg       <= 1'b0;
      valid_reg     <= 1'b0;
      rgb_reg       <= '0;
      rgb_valid_reg <= 1'b0;
    end else begin
      hit_reg       <= hit_next;
      valid_reg     <= px_valid;
      rgb_valid_reg <= valid_reg;
      if (!valid_reg)
        rgb_reg <= 12'h000;
      else if (hit_reg)
        rgb_reg <= BALL_RGB;
      else
        rgb_reg <= BG_RGB;
    end
  end

  assign RED       = rgb_reg[11:8];
  assign GREEN     = rgb_reg[7:4];
  assign BLUE      = rgb_reg[3:0];
  assign rgb_valid = rgb_valid_reg;

endmodule

// File: tb/tb_ball_renderer.sv
// Directed bench for ball_renderer: pixel vectors from a table, then multi-frame physics sequences
// on four instances that differ only in their reset position/velocity.
module tb_ball_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] px_col = '0;
  logic [10:0] px_row = '0;
  logic        px_valid = 1'b0;
  logic        frame_start = 1'b0;

  logic [3:0] red_o   [4];
  logic [3:0] green_o [4];
  logic [3:0] blue_o  [4];
  logic       rv_o    [4];
  logic       busy_o  [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ball_renderer u_dut (
    .clock_162(clk), .rst(rst), .px_col(px_col), .px_row(px_row), .px_valid(px_valid),
    .frame_start(frame_start), .RED(red_o[0]), .GREEN(green_o[0]), .BLUE(blue_o[0]),
    .rgb_valid(rv_o[0]), .busy(busy_o[0])
  );
  ball_renderer #(.Y0(1180), .VY0(10)) u_floor (
    .clock_162(clk), .rst(rst), .px_col(px_col), .px_row(px_row), .px_valid(px_valid),
    .frame_start(frame_start), .RED(red_o[1]), .GREEN(green_o[1]), .BLUE(blue_o[1]),
    .rgb_valid(rv_o[1]), .busy(busy_o[1])
  );
  ball_renderer #(.X0(2), .VX0(-3)) u_wall (
    .clock_162(clk), .rst(rst), .px_col(px_col), .px_row(px_row), .px_valid(px_valid),
    .frame_start(frame_start), .RED(red_o[2]), .GREEN(green_o[2]), .BLUE(blue_o[2]),
    .rgb_valid(rv_o[2]), .busy(busy_o[2])
  );
  ball_renderer #(.VY0(24)) u_sat (
    .clock_162(clk), .rst(rst), .px_col(px_col), .px_row(px_row), .px_valid(px_valid),
    .frame_start(frame_start), .RED(red_o[3]), .GREEN(green_o[3]), .BLUE(blue_o[3]),
    .rgb_valid(rv_o[3]), .busy(busy_o[3])
  );

  typedef struct {
    logic        valid;
    logic [10:0] col;
    logic [10:0] row;
    logic [11:0] rgb;
    logic        rv;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("[TB] ok   %s = %0d", name, act);
    end
  endtask

  function automatic int dut_rgb();
    return int'({red_o[0], green_o[0], blue_o[0]});
  endfunction

  // One frame_start pulse; counts busy cycles (bounded). Optionally injects a second
  // pulse while busy and drives a ball-corner pixel in the COMMIT cycle.
  task automatic run_frame(input bit glitch, input bit pix_at_commit, output int busy_cycles);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy_o[0]) break;
      busy_cycles++;
      frame_start = (glitch && i == 1);
      if (pix_at_commit && i == 3) begin
        px_valid = 1'b1;
        px_col   = 11'd100;
        px_row   = 11'd100;
      end
      @(negedge clk);
    end
    frame_start = 1'b0;
  endtask

  initial begin
    int bc;
    logic [11:0] prev_rgb;
    logic        prev_rv;

    vecs[0] = '{1'b1, 11'd100,  11'd100,  12'hF80, 1'b1};
    vecs[1] = '{1'b1, 11'd116,  11'd100,  12'h004, 1'b1};
    vecs[2] = '{1'b0, 11'd105,  11'd105,  12'h000, 1'b0};
    vecs[3] = '{1'b1, 11'd115,  11'd115,  12'hF80, 1'b1};
    vecs[4] = '{1'b1, 11'd99,   11'd105,  12'h004, 1'b1};
    vecs[5] = '{1'b1, 11'd105,  11'd116,  12'h004, 1'b1};
    vecs[6] = '{1'b1, 11'd105,  11'd99,   12'h004, 1'b1};
    vecs[7] = '{1'b1, 11'd0,    11'd0,    12'h004, 1'b1};
    vecs[8] = '{1'b1, 11'd1599, 11'd1199, 12'h004, 1'b1};
    vecs[9] = '{1'b0, 11'd0,    11'd0,    12'h000, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy_o[0]), 0);
    check("reset_rgb", dut_rgb(), 0);
    check("reset_rgb_valid", int'(rv_o[0]), 0);
    check("reset_dx", int'(u_dut.dx_reg), 100);
    check("reset_dy", int'(u_dut.dy_reg), 100);
    check("reset_vx", int'($signed(u_dut.vx_reg)), 3);
    check("reset_vy", int'($signed(u_dut.vy_reg)), 0);
    check("reset_wall_vx", int'($signed(u_wall.vx_reg)), -3);
    rst = 1'b0;
    @(negedge clk);

    prev_rgb = 12'h000;
    prev_rv  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      px_valid = vecs[i].valid;
      px_col   = vecs[i].col;
      px_row   = vecs[i].row;
      @(negedge clk);
      check($sformatf("vec%0d_rgb_1cyc", i), dut_rgb(), int'(prev_rgb));
      @(negedge clk);
      check($sformatf("vec%0d_rgb", i), dut_rgb(), int'(vecs[i].rgb));
      check($sformatf("vec%0d_rgb_valid", i), int'(rv_o[0]), int'(vecs[i].rv));
      prev_rgb = vecs[i].rgb;
      prev_rv  = vecs[i].rv;
    end
    px_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1: second pulse during busy, and a pixel sampled in the COMMIT cycle.
    run_frame(1'b1, 1'b1, bc);
    check("f1_busy_cycles", bc, 4);
    @(negedge clk);
    check("commit_pixel_old_pos", dut_rgb(), 12'hF80);
    @(negedge clk);
    check("next_pixel_new_pos", dut_rgb(), 12'h004);
    px_valid = 1'b0;
    check("f1_dx", int'(u_dut.dx_reg), 103);
    check("f1_dy", int'(u_dut.dy_reg), 101);
    check("f1_vy", int'($signed(u_dut.vy_reg)), 1);
    check("floor_py", int'(u_floor.py_reg), 1184);
    check("floor_vy", int'($signed(u_floor.vy_reg)), -11);
    check("floor_dy", int'(u_floor.dy_reg), 1184);
    check("wall_px", int'(u_wall.px_reg), 0);
    check("wall_vx", int'($signed(u_wall.vx_reg)), 3);
    check("wall_dx", int'(u_wall.dx_reg), 0);
    check("sat_f1_vy", int'($signed(u_sat.vy_reg)), 24);
    check("sat_f1_py", int'(u_sat.py_reg), 124);

    run_frame(1'b0, 1'b0, bc);
    check("f2_busy_cycles", bc, 4);
    check("floor_f2_py", int'(u_floor.py_reg), 1174);
    check("floor_f2_vy", int'($signed(u_floor.vy_reg)), -10);
    check("wall_f2_px", int'(u_wall.px_reg), 3);
    check("sat_f2_vy", int'($signed(u_sat.vy_reg)), 24);
    check("sat_f2_py", int'(u_sat.py_reg), 148);

    run_frame(1'b0, 1'b0, bc);
    check("f3_dx", int'(u_dut.dx_reg), 109);
    check("f3_dy", int'(u_dut.dy_reg), 106);
    check("f3_vy", int'($signed(u_dut.vy_reg)), 3);
    check("sat_f3_vy", int'($signed(u_sat.vy_reg)), 24);
    check("sat_f3_dy", int'(u_sat.dy_reg), 172);

    // Reset in the middle of an update (state MOVE, gravity already applied).
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    check("mid_vy_before_rst", int'($signed(u_dut.vy_reg)), 4);
    rst = 1'b1;
    #1;
    check("async_rst_busy", int'(busy_o[0]), 0);
    check("async_rst_vy", int'($signed(u_dut.vy_reg)), 0);
    check("async_rst_px", int'(u_dut.px_reg), 100);
    check("async_rst_dx", int'(u_dut.dx_reg), 100);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_idle_busy", int'(busy_o[0]), 0);
    check("post_rst_no_commit_dx", int'(u_dut.dx_reg), 100);
    check("post_rst_no_commit_dy", int'(u_dut.dy_reg), 100);

    run_frame(1'b0, 1'b0, bc);
    check("post_rst_busy_cycles", bc, 4);
    check("post_rst_dx", int'(u_dut.dx_reg), 103);
    check("post_rst_dy", int'(u_dut.dy_reg), 101);
    check("post_rst_vy", int'($signed(u_dut.vy_reg)), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
